// File: rtl/fmap_pkg.sv
// Shared types for the field-map sequencer: status codes, FSM states,
// descriptor layout and header field positions.
package fmap_pkg;

    localparam int POS_W = 11;

    localparam logic [4:0] ST_CLEAR = 5'd0;
    localparam logic [4:0] ST_LOAD  = 5'd1;

    localparam int HDR_ST_HI = 9;
    localparam int HDR_ST_LO = 5;
    localparam int HDR_NV_HI = 4;
    localparam int HDR_NV_LO = 0;

    typedef enum logic [2:0] {
        S_HDR     = 3'd0,
        S_START   = 3'd1,
        S_END     = 3'd2,
        S_READY   = 3'd3,
        S_EXTRACT = 3'd4
    } fsm_t;

    typedef struct packed {
        logic [POS_W-1:0] start_pos;
        logic [POS_W-1:0] end_pos;
    } desc_t;

    // Inclusive field length; only meaningful when start_pos <= end_pos.
    function automatic logic [POS_W-1:0] field_len(input desc_t d);
        return d.end_pos - d.start_pos + POS_W'(1);
    endfunction

endpackage

// File: rtl/fmap_field_extract.sv
// Combinational extraction of one descriptor's field from a packet,
// LSB-aligned and zero-extended to RR_W.
module fmap_field_extract
    import fmap_pkg::*;
#(
    parameter int PACKET_SIZE = 40,
    parameter int RR_W        = 16
) (
    input  logic [PACKET_SIZE-1:0] pkt,
    input  desc_t                  desc,
    output logic [RR_W-1:0]        field
);

    logic [POS_W-1:0] len_s;
    logic [RR_W-1:0]  mask_s;

    // Build the length mask without wrapping when the field spans all of RR_W.
    always_comb begin
        len_s = field_len(desc);
        if (len_s >= POS_W'(RR_W)) begin
            mask_s = {RR_W{1'b1}};
        end else begin
            mask_s = (RR_W'(1) << len_s) - RR_W'(1);
        end
        field = RR_W'(pkt >> desc.start_pos) & mask_s;
    end

endmodule

// File: rtl/field_map_sequencer.sv
// Loads a field-map program into a descriptor table, then writes each mapped
// packet field into RR0..RRn-1, one per cycle. FMAP_STATS_EN adds pkt_count.
module field_map_sequencer
    import fmap_pkg::*;
#(
    parameter int PACKET_SIZE = 40,
    parameter int NUM_RR      = 8,
    parameter int RR_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [POS_W-1:0]          cfg_data,
    input  logic                      pkt_valid,
    output logic                      pkt_ready,
    input  logic [PACKET_SIZE-1:0]    pkt_data,
    output logic                      rr_we,
    output logic [$clog2(NUM_RR)-1:0] rr_idx,
    output logic [RR_W-1:0]           rr_wdata,
    output logic                      pkt_done,
`ifdef FMAP_STATS_EN
    output logic [15:0]               pkt_count,
`endif
    output logic                      cfg_loaded,
    output logic                      cfg_err
);

    localparam int IDX_W = $clog2(NUM_RR);
    localparam int CNT_W = $clog2(NUM_RR + 1);

    fsm_t                   state_r, state_s;
    desc_t                  desc_r [NUM_RR];
    desc_t                  pair_s;
    logic [POS_W-1:0]       start_r;
    logic [IDX_W-1:0]       i_r, k_r;
    logic [CNT_W-1:0]       nvars_r;
    logic [PACKET_SIZE-1:0] pkt_r, ext_pkt_s;
    logic [4:0]             hdr_status_s, hdr_nvars_s;
    logic                   cfg_fire_s, pkt_fire_s, nvars_ok_s, pair_bad_s;
    logic                   load_last_s, ext_last_s;
    logic                   hdr_load_s, hdr_clear_s, cfg_error_s, start_beat_s, pair_store_s, load_done_s;
    logic                   cfg_ready_r, pkt_ready_r, cfg_ready_s, pkt_ready_s;
    logic                   rr_we_r, rr_we_s, pkt_done_r, pkt_done_s, loaded_r, err_r;
    logic [IDX_W-1:0]       rr_idx_r, rr_idx_s;
    logic [RR_W-1:0]        rr_wdata_r, field_s;

    // A waiting packet takes priority over a config beat in READY.
    assign cfg_ready    = cfg_ready_r & ~(pkt_valid & pkt_ready_r);
    assign pkt_ready    = pkt_ready_r;
    assign rr_we        = rr_we_r;
    assign rr_idx       = rr_idx_r;
    assign rr_wdata     = rr_wdata_r;
    assign pkt_done     = pkt_done_r;
    assign cfg_loaded   = loaded_r;
    assign cfg_err      = err_r;

    assign cfg_fire_s   = cfg_valid & cfg_ready;
    assign pkt_fire_s   = pkt_valid & pkt_ready_r;
    assign hdr_status_s = cfg_data[HDR_ST_HI:HDR_ST_LO];
    assign hdr_nvars_s  = cfg_data[HDR_NV_HI:HDR_NV_LO];
    assign nvars_ok_s   = (hdr_nvars_s != 5'd0) && (hdr_nvars_s <= 5'(NUM_RR));
    assign pair_s       = '{start_pos: start_r, end_pos: cfg_data};
    assign pair_bad_s   = (start_r > cfg_data) || (cfg_data >= POS_W'(PACKET_SIZE)) ||
                          (field_len(pair_s) > POS_W'(RR_W));
    assign load_last_s  = (CNT_W'(i_r) + CNT_W'(1)) == nvars_r;
    assign ext_last_s   = (state_r == S_EXTRACT) && ((CNT_W'(k_r) + CNT_W'(1)) == nvars_r);
    assign ext_pkt_s    = pkt_fire_s ? pkt_data : pkt_r;

    fmap_field_extract #(.PACKET_SIZE(PACKET_SIZE), .RR_W(RR_W)) u_extract (
        .pkt   (ext_pkt_s),
        .desc  (desc_r[rr_idx_s]),
        .field (field_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= S_HDR;
        else     state_r <= state_s;
    end

    // Next-state logic and program-load strobes.
    always_comb begin
        state_s      = state_r;
        hdr_load_s   = 1'b0;
        hdr_clear_s  = 1'b0;
        cfg_error_s  = 1'b0;
        start_beat_s = 1'b0;
        pair_store_s = 1'b0;
        load_done_s  = 1'b0;
        case (state_r)
            S_HDR, S_READY: begin
                if (pkt_fire_s) begin
                    state_s = S_EXTRACT;
                end else if (cfg_fire_s) begin
                    if (hdr_status_s == ST_LOAD && nvars_ok_s) begin
                        hdr_load_s = 1'b1;
                        state_s    = S_START;
                    end else if (hdr_status_s == ST_CLEAR) begin
                        hdr_clear_s = 1'b1;
                        state_s     = S_HDR;
                    end else begin
                        cfg_error_s = 1'b1;
                        state_s     = S_HDR;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            S_START: begin
                if (cfg_fire_s) begin
                    start_beat_s = 1'b1;
                    state_s      = S_END;
                end else begin
                    state_s = S_START;
                end
            end
            S_END: begin
                if (cfg_fire_s && pair_bad_s) begin
                    cfg_error_s = 1'b1;
                    state_s     = S_HDR;
                end else if (cfg_fire_s) begin
                    pair_store_s = 1'b1;
                    load_done_s  = load_last_s;
                    state_s      = load_last_s ? S_READY : S_START;
                end else begin
                    state_s = S_END;
                end
            end
            S_EXTRACT: begin
                if (ext_last_s) state_s = S_READY;
                else            state_s = S_EXTRACT;
            end
            default: state_s = S_HDR;
        endcase
    end

    // Next values of the registered outputs; the first field is taken straight from pkt_data.
    always_comb begin
        cfg_ready_s = (state_s != S_EXTRACT);
        pkt_ready_s = (state_s == S_READY);
        rr_we_s     = 1'b0;
        rr_idx_s    = '0;
        pkt_done_s  = 1'b0;
        if (pkt_fire_s) begin
            rr_we_s = 1'b1;
        end else if (state_r == S_EXTRACT && !ext_last_s) begin
            rr_we_s  = 1'b1;
            rr_idx_s = k_r + IDX_W'(1);
        end else if (state_r == S_EXTRACT) begin
            pkt_done_s = 1'b1;
        end else begin
            rr_we_s = 1'b0;
        end
    end

    // Registered handshake and reserved-register write outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ready_r <= 1'b0;
            pkt_ready_r <= 1'b0;
            rr_we_r     <= 1'b0;
            rr_idx_r    <= '0;
            rr_wdata_r  <= '0;
            pkt_done_r  <= 1'b0;
        end else begin
            cfg_ready_r <= cfg_ready_s;
            pkt_ready_r <= pkt_ready_s;
            rr_we_r     <= rr_we_s;
            rr_idx_r    <= rr_idx_s;
            rr_wdata_r  <= rr_we_s ? field_s : '0;
            pkt_done_r  <= pkt_done_s;
        end
    end

    // Map status flags; a LOAD header invalidates the old map immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loaded_r <= 1'b0;
            err_r    <= 1'b0;
        end else if (cfg_error_s) begin
            loaded_r <= 1'b0;
            err_r    <= 1'b1;
        end else if (hdr_clear_s) begin
            loaded_r <= 1'b0;
            err_r    <= 1'b0;
        end else if (hdr_load_s) begin
            loaded_r <= 1'b0;
        end else if (load_done_s) begin
            loaded_r <= 1'b1;
            err_r    <= 1'b0;
        end
    end

    // Descriptor table, load index, packet register and extraction index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM_RR; j++) desc_r[j] <= '0;
            start_r <= '0;
            i_r     <= '0;
            k_r     <= '0;
            nvars_r <= '0;
            pkt_r   <= '0;
        end else begin
            if (hdr_load_s) begin
                nvars_r <= CNT_W'(hdr_nvars_s);
                i_r     <= '0;
            end
            if (start_beat_s) start_r <= cfg_data;
            if (pair_store_s) begin
                desc_r[i_r] <= pair_s;
                i_r         <= i_r + IDX_W'(1);
            end
            if (pkt_fire_s) begin
                pkt_r <= pkt_data;
                k_r   <= '0;
            end else if (state_r == S_EXTRACT) begin
                k_r <= k_r + IDX_W'(1);
            end
        end
    end

`ifdef FMAP_STATS_EN
    logic        stat_clr_s;
    logic [15:0] pkt_count_r;

    assign stat_clr_s = cfg_fire_s && (state_r == S_HDR || state_r == S_READY) &&
                        (hdr_status_s == ST_LOAD || hdr_status_s == ST_CLEAR);
    assign pkt_count  = pkt_count_r;

    // Saturating count of completed packets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       pkt_count_r <= 16'd0;
        else if (stat_clr_s)                           pkt_count_r <= 16'd0;
        else if (pkt_done_s && pkt_count_r != 16'hFFFF) pkt_count_r <= pkt_count_r + 16'd1;
    end
`endif

endmodule

// File: tb/tb_field_map_sequencer.sv
// Scoreboard bench for field_map_sequencer: stimulus pushes expected RR writes,
// a negedge monitor pops and compares them.
module tb_field_map_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready, pkt_valid, pkt_ready;
    logic [10:0] cfg_data;
    logic [39:0] pkt_data;
    logic        rr_we, pkt_done, cfg_loaded, cfg_err;
    logic [2:0]  rr_idx;
    logic [15:0] rr_wdata;
`ifdef FMAP_STATS_EN
    logic [15:0] pkt_count;
`endif

    always #5 clk = ~clk;

    field_map_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .rr_we(rr_we), .rr_idx(rr_idx), .rr_wdata(rr_wdata), .pkt_done(pkt_done),
`ifdef FMAP_STATS_EN
        .pkt_count(pkt_count),
`endif
        .cfg_loaded(cfg_loaded), .cfg_err(cfg_err)
    );

    typedef struct {
        bit          is_done;
        int          idx;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state
    bit   m_loaded, m_err;
    int   m_nv, m_count;
    int   ms[8], me[8];
    int   sa[8], ea[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mfield(input logic [39:0] p, input int s, input int e);
        logic [63:0] w;
        w = {24'd0, p} >> s;
        w = w & ((64'd1 << (e - s + 1)) - 64'd1);
        return w[15:0];
    endfunction

    // Monitor: every DUT output event is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (rr_we) begin
                if (q.size() == 0 || q[0].is_done) begin
                    checks++; errors++;
                    $display("FAIL rr_unexpected actual idx=%0d data=0x%0h required none", rr_idx, rr_wdata);
                end else begin
                    mon_e = q.pop_front();
                    chk("rr_idx", 64'(rr_idx), 64'(mon_e.idx));
                    chk("rr_wdata", 64'(rr_wdata), 64'(mon_e.data));
                    chk("rr_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            if (pkt_done) begin
                if (q.size() == 0 || !q[0].is_done) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected actual pkt_done=1 required 0 (queue=%0d)", q.size());
                end else begin
                    mon_e = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            chk("ready_needs_map", 64'(pkt_ready & ~cfg_loaded), 64'd0);
        end
    end

    task automatic push_pkt(input logic [39:0] p, input int acc);
        for (int k = 0; k < m_nv; k++) q.push_back('{1'b0, k, mfield(p, ms[k], me[k]), acc + k});
        q.push_back('{1'b1, 0, 16'd0, acc + m_nv});
        if (m_count < 65535) m_count++;
    endtask

    task automatic send_beat(input logic [10:0] d);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_data = d;
        #1;
        for (int n = 0; n < 50 && !cfg_ready; n++) begin @(negedge clk); #1; end
        chk("cfg_beat_accept", 64'(cfg_ready), 64'd1);
        if (cfg_ready) begin @(posedge clk); #1; end
        cfg_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [39:0] p);
        @(negedge clk);
        pkt_valid = 1'b1; pkt_data = p;
        #1;
        for (int n = 0; n < 50 && !pkt_ready; n++) begin @(negedge clk); #1; end
        chk("pkt_accept", 64'(pkt_ready), 64'd1);
        if (pkt_ready) begin
            push_pkt(p, cyc + 1);
            @(posedge clk); #1;
        end
        pkt_valid = 1'b0;
    endtask

    task automatic send_program(input int st, input int nv);
        bit bad;
        send_beat({1'b0, 5'(st), 5'(nv)});
        if (st == 0 || st == 1) m_count = 0;
        if (st == 0) begin
            m_loaded = 0; m_err = 0;
        end else if (st != 1 || nv == 0 || nv > 8) begin
            m_loaded = 0; m_err = 1;
        end else begin
            m_loaded = 0; bad = 0;
            for (int i = 0; i < nv && !bad; i++) begin
                send_beat(11'(sa[i]));
                send_beat(11'(ea[i]));
                if (sa[i] > ea[i] || ea[i] >= 40 || ea[i] - sa[i] + 1 > 16) bad = 1;
            end
            if (bad) m_err = 1;
            else begin
                m_loaded = 1; m_err = 0; m_nv = nv;
                for (int i = 0; i < nv; i++) begin ms[i] = sa[i]; me[i] = ea[i]; end
            end
        end
        @(negedge clk);
        chk("cfg_loaded", 64'(cfg_loaded), 64'(m_loaded));
        chk("cfg_err", 64'(cfg_err), 64'(m_err));
`ifdef FMAP_STATS_EN
        chk("pkt_count_prog", 64'(pkt_count), 64'(m_count));
`endif
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && q.size() != 0; n++) @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic load_t1();
        sa[0] = 0;  ea[0] = 15;
        sa[1] = 16; ea[1] = 30;
        sa[2] = 31; ea[2] = 39;
        send_program(1, 3);
    endtask

    task automatic rand_program();
        int r, nv, s, len, j;
        r  = $urandom_range(0, 9);
        nv = $urandom_range(1, 8);
        for (int i = 0; i < 8; i++) begin
            s = $urandom_range(0, 39);
            len = $urandom_range(1, (40 - s) < 16 ? (40 - s) : 16);
            sa[i] = s; ea[i] = s + len - 1;
        end
        if (r == 0) send_program($urandom_range(2, 31), nv);
        else if (r == 1) send_program(1, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 31));
        else if (r == 2) begin
            j = $urandom_range(0, nv - 1);
            case ($urandom_range(0, 2))
                0: begin sa[j] = 20; ea[j] = 19; end
                1: begin sa[j] = 35; ea[j] = $urandom_range(40, 45); end
                default: begin sa[j] = 2; ea[j] = 2 + $urandom_range(16, 30); end
            endcase
            send_program(1, nv);
        end
        else if (r == 3) send_program(0, 0);
        else send_program(1, nv);
        if (m_loaded) begin
            for (int p = 0, np = $urandom_range(1, 3); p < np; p++)
                send_pkt({$urandom_range(0, 255), $urandom()});
            drain();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; pkt_valid = 1'b0; pkt_data = '0;
        m_loaded = 0; m_err = 0; m_nv = 0; m_count = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rr_we", 64'(rr_we), 64'd0);
        chk("rst_pkt_done", 64'(pkt_done), 64'd0);
        chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        chk("rst_loaded", 64'(cfg_loaded), 64'd0);
        chk("rst_err", 64'(cfg_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("hdr_cfg_ready", 64'(cfg_ready), 64'd1);

        // 1: fixed three-field map
        load_t1();
        send_pkt(40'hA512345678);
        drain();

        // 2: inverted pair, no packet accepted while unloaded, then recovery
        sa[0] = 20; ea[0] = 10;
        send_program(1, 1);
        @(negedge clk); pkt_valid = 1'b1; pkt_data = 40'h1;
        for (int n = 0; n < 5; n++) begin #1; chk("t2_pkt_ready", 64'(pkt_ready), 64'd0); @(negedge clk); end
        pkt_valid = 1'b0;
        sa[0] = 4; ea[0] = 11;
        send_program(1, 1);

        // 3: end beyond packet, too many vars, bad status
        sa[0] = 31; ea[0] = 40;
        send_program(1, 1);
        send_program(1, 9);
        send_program(3, 1);

        // 4: packet wins over a simultaneous header
        load_t1();
        begin
            int acc;
            @(negedge clk);
            pkt_valid = 1'b1; pkt_data = 40'h00FEDCBA98;
            cfg_valid = 1'b1; cfg_data = 11'h000;
            #1;
            chk("t4_pkt_ready", 64'(pkt_ready), 64'd1);
            chk("t4_cfg_blocked", 64'(cfg_ready), 64'd0);
            acc = cyc + 1;
            push_pkt(40'h00FEDCBA98, acc);
            @(posedge clk); #1;
            pkt_valid = 1'b0;
            for (int n = 0; n < 30; n++) begin @(negedge clk); #1; if (cfg_ready) break; end
            chk("t4_cfg_at_done", 64'(pkt_done), 64'd1);
            chk("t4_cfg_cycle", 64'(cyc), 64'(acc + 3));
            @(posedge clk); #1;
            cfg_valid = 1'b0;
            m_loaded = 0; m_err = 0; m_count = 0;
            @(negedge clk);
            chk("t4_cleared", 64'(cfg_loaded), 64'd0);
        end

        // Randomised programs and packets
        for (int it = 0; it < 24; it++) rand_program();

        // 5: reset in the middle of extraction
        load_t1();
        send_pkt(40'h123456789A);
        for (int n = 0; n < 10; n++) begin @(negedge clk); if (rr_we && rr_idx == 3'd1) break; end
        #1; rst = 1'b1; q.delete();
        #1;
        chk("t5_rr_we", 64'(rr_we), 64'd0);
        chk("t5_loaded", 64'(cfg_loaded), 64'd0);
        chk("t5_pkt_ready", 64'(pkt_ready), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        m_loaded = 0; m_err = 0; m_nv = 0; m_count = 0;
        for (int n = 0; n < 8; n++) begin @(negedge clk); chk("t5_no_done", 64'(pkt_done), 64'd0); end

`ifdef FMAP_STATS_EN
        // 6: packet counter and its clear
        chk("t6_count_rst", 64'(pkt_count), 64'd0);
        load_t1();
        for (int p = 0; p < 3; p++) send_pkt({$urandom_range(0, 255), $urandom()});
        drain();
        chk("t6_count3", 64'(pkt_count), 64'd3);
        send_program(0, 0);
        chk("t6_count_clr", 64'(pkt_count), 64'd0);
`endif

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
